unidade_controle: RTL and testbench

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

---
 rtl/unidade_controle_pkg.sv | 65 ++++++
 rtl/unidade_controle_decodificador.sv | 26 ++
 rtl/unidade_controle.sv | 109 ++++++++++
 tb/tb_unidade_controle.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/unidade_controle_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, instruction
// classes, opcode constants and datapath mux-select values.
package unidade_controle_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERRO   = 3'd6
  } estado_t;

  typedef enum logic [2:0] {
    C_R      = 3'd0,
    C_I      = 3'd1,
    C_LOAD   = 3'd2,
    C_STORE  = 3'd3,
    C_BRANCH = 3'd4,
    C_AUIPC  = 3'd5,
    C_JAL    = 3'd6
  } classe_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic       MUX1_IMM   = 1'b0;
  localparam logic       MUX1_DOUTB = 1'b1;
  localparam logic [1:0] MUX2_MEM   = 2'd0;
  localparam logic [1:0] MUX2_ULA   = 2'd1;
  localparam logic [1:0] MUX2_PC4   = 2'd2;
  localparam logic [1:0] MUX2_PCIMM = 2'd3;
  localparam logic       MUX4_DOUTA = 1'b0;
  localparam logic       MUX4_PC    = 1'b1;

  typedef struct packed {
    logic       mux1;
    logic [1:0] mux2;
    logic       mux4;
  } sel_t;

  // Datapath selects latched on entry to EXEC and held until the instruction retires.
  function automatic sel_t sel_de_classe(input classe_t c);
    sel_t s;
    s = '{mux1: MUX1_IMM, mux2: MUX2_MEM, mux4: MUX4_DOUTA};
    case (c)
      C_R:      s = '{mux1: MUX1_DOUTB, mux2: MUX2_ULA,   mux4: MUX4_DOUTA};
      C_I:      s = '{mux1: MUX1_IMM,   mux2: MUX2_ULA,   mux4: MUX4_DOUTA};
      C_LOAD:   s = '{mux1: MUX1_IMM,   mux2: MUX2_MEM,   mux4: MUX4_DOUTA};
      C_STORE:  s = '{mux1: MUX1_IMM,   mux2: MUX2_MEM,   mux4: MUX4_DOUTA};
      C_BRANCH: s = '{mux1: MUX1_DOUTB, mux2: MUX2_MEM,   mux4: MUX4_PC};
      C_AUIPC:  s = '{mux1: MUX1_IMM,   mux2: MUX2_PCIMM, mux4: MUX4_PC};
      C_JAL:    s = '{mux1: MUX1_IMM,   mux2: MUX2_PC4,   mux4: MUX4_PC};
      default:  s = '{mux1: MUX1_IMM,   mux2: MUX2_MEM,   mux4: MUX4_DOUTA};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/unidade_controle_decodificador.sv
// Combinational opcode classifier: maps the 7-bit opcode to an instruction
// class and flags anything outside the supported set as illegal.
module decodificador_opcode
  import unidade_controle_pkg::*;
(
  input  logic [6:0] i_opcode,
  output classe_t    o_classe,
  output logic       o_legal
);

  always_comb begin
    o_classe = C_R;
    o_legal  = 1'b1;
    case (i_opcode)
      OP_R:      o_classe = C_R;
      OP_I:      o_classe = C_I;
      OP_LOAD:   o_classe = C_LOAD;
      OP_STORE:  o_classe = C_STORE;
      OP_BRANCH: o_classe = C_BRANCH;
      OP_AUIPC:  o_classe = C_AUIPC;
      OP_JAL:    o_classe = C_JAL;
      default:   o_legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control FSM: sequences fetch/decode/exec/mem/wb, drives registered
// write enables and datapath selects, counts retired instructions.
module unidade_controle
  import unidade_controle_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        flag,
  output logic        wePC,
  output logic        weIR,
  output logic        weReg,
  output logic        weMem,
  output logic        sinalMux1,
  output logic [1:0]  sinalMux2,
  output logic        sinalMux4,
  output logic [2:0]  estado,
  output logic        erro,
  output logic [31:0] instret
);

  estado_t     r_estado;
  classe_t     r_classe;
  sel_t        r_sel;
  logic        r_wePC, r_weIR, r_weReg, r_weMem, r_erro;
  logic [31:0] r_instret;

  classe_t     w_classe;
  logic        w_legal;
  // The branch decision is taken by Mux3 in the datapath; the FSM timing is flag-independent.
  logic        w_unused_flag;
  assign w_unused_flag = flag;

  decodificador_opcode u_dec (
    .i_opcode (opcode),
    .o_classe (w_classe),
    .o_legal  (w_legal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado  <= S_IDLE;
      r_classe  <= C_R;
      r_sel     <= '0;
      r_wePC    <= 1'b0;
      r_weIR    <= 1'b0;
      r_weReg   <= 1'b0;
      r_weMem   <= 1'b0;
      r_erro    <= 1'b0;
      r_instret <= '0;
    end else begin
      r_wePC  <= 1'b0;
      r_weIR  <= 1'b0;
      r_weReg <= 1'b0;
      r_weMem <= 1'b0;
      if (r_wePC) r_instret <= r_instret + 32'd1;
      // wePC marks the final state of every instruction, whatever that state is.
      if (r_wePC) begin
        r_estado <= run ? S_FETCH : S_IDLE;
        r_weIR   <= run;
      end else begin
        case (r_estado)
          S_IDLE: if (run) begin
            r_estado <= S_FETCH;
            r_weIR   <= 1'b1;
          end
          S_FETCH: r_estado <= S_DECODE;
          S_DECODE: if (w_legal) begin
            r_estado <= S_EXEC;
            r_classe <= w_classe;
            r_sel    <= sel_de_classe(w_classe);
            r_wePC   <= (w_classe == C_BRANCH);
          end else begin
            r_estado <= S_ERRO;
            r_erro   <= 1'b1;
          end
          S_EXEC: if (r_classe == C_LOAD || r_classe == C_STORE) begin
            r_estado <= S_MEM;
            r_weMem  <= (r_classe == C_STORE);
            r_wePC   <= (r_classe == C_STORE);
          end else begin
            r_estado <= S_WB;
            r_weReg  <= 1'b1;
            r_wePC   <= 1'b1;
          end
          S_MEM: begin
            r_estado <= S_WB;
            r_weReg  <= 1'b1;
            r_wePC   <= 1'b1;
          end
          default: r_estado <= r_estado;
        endcase
      end
    end
  end

  assign wePC      = r_wePC;
  assign weIR      = r_weIR;
  assign weReg     = r_weReg;
  assign weMem     = r_weMem;
  assign sinalMux1 = r_sel.mux1;
  assign sinalMux2 = r_sel.mux2;
  assign sinalMux4 = r_sel.mux4;
  assign estado    = r_estado;
  assign erro      = r_erro;
  assign instret   = r_instret;

endmodule

// File: tb/tb_unidade_controle.sv
// Scoreboard bench: stimulus queues expected retirements and state snapshots,
// a negedge monitor pops and compares them against the control outputs.
module tb_unidade_controle;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic        flag = 1'b0;
  logic        wePC, weIR, weReg, weMem, sinalMux1, sinalMux4, erro;
  logic [1:0]  sinalMux2;
  logic [2:0]  estado;
  logic [31:0] instret;

  unidade_controle dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .flag(flag),
    .wePC(wePC), .weIR(weIR), .weReg(weReg), .weMem(weMem),
    .sinalMux1(sinalMux1), .sinalMux2(sinalMux2), .sinalMux4(sinalMux4),
    .estado(estado), .erro(erro), .instret(instret)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       nm;
    logic        m1;
    logic [1:0]  m2;
    logic        m4;
    bit          ck_m2;
    logic        wr;
    logic        wm;
    logic [2:0]  est;
    int          lat;
    logic [31:0] ir;
  } ret_t;

  typedef struct {
    string       nm;
    logic [7:0]  ctl;   // {weIR,wePC,weReg,weMem,erro,estado}
    logic [31:0] ir;
    bit          ck_mux;
    logic [3:0]  mux;   // {mux1,mux2,mux4}
  } snap_t;

  ret_t        retire_q[$];
  snap_t       snap_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  bit          done = 1'b0;
  logic [31:0] exp_ret = '0;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, AU = 7'b0010111, JL = 7'b1101111, BAD = 7'b1111111;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: the only process that compares.
  initial begin
    int lat;
    int cyc;
    ret_t  e;
    snap_t s;
    lat = 0;
    cyc = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (done || cyc > 3000) begin
        if (!done) chk("watchdog_cycles", 32'(cyc), 32'd0);
        chk("retire_q_drained", 32'(retire_q.size()), 32'd0);
        chk("snap_q_drained", 32'(snap_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
      end
      if (weIR) lat = 1; else lat++;
      if (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        chk({s.nm, " ctl"}, {24'd0, weIR, wePC, weReg, weMem, erro, estado}, {24'd0, s.ctl});
        chk({s.nm, " instret"}, instret, s.ir);
        if (s.ck_mux) chk({s.nm, " mux"}, {28'd0, sinalMux1, sinalMux2, sinalMux4}, {28'd0, s.mux});
      end
      if (weReg) chk("weReg_only_in_WB", {29'd0, estado}, 32'd5);
      if (weMem) chk("weMem_only_in_MEM", {29'd0, estado}, 32'd4);
      if (wePC) begin
        if (retire_q.size() == 0) chk("unexpected_wePC", 32'd1, 32'd0);
        else begin
          e = retire_q.pop_front();
          chk({e.nm, " latency"}, 32'(lat), 32'(e.lat));
          chk({e.nm, " wr/wm/estado"}, {27'd0, weReg, weMem, estado}, {27'd0, e.wr, e.wm, e.est});
          chk({e.nm, " mux1/mux4"}, {30'd0, sinalMux1, sinalMux4}, {30'd0, e.m1, e.m4});
          if (e.ck_m2) chk({e.nm, " mux2"}, {30'd0, sinalMux2}, {30'd0, e.m2});
          chk({e.nm, " instret"}, instret, e.ir);
        end
      end
    end
  end

  task automatic push_snap(input string nm, input logic [7:0] ctl, input logic [31:0] ir,
                           input bit ck, input logic [3:0] mux);
    snap_t s;
    s.nm = nm; s.ctl = ctl; s.ir = ir; s.ck_mux = ck; s.mux = mux;
    snap_q.push_back(s);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_wepc(input string nm);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (wePC) return;
    end
    $display("FAIL %s: wePC never asserted within 16 cycles", nm);
    $fatal(1, "timeout");
  endtask

  task automatic wait_estado(input string nm, input logic [2:0] est);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (estado == est) return;
    end
    $display("FAIL %s: estado %0d never reached", nm, est);
    $fatal(1, "timeout");
  endtask

  task automatic do_instr(input string nm, input logic [6:0] op, input logic m1,
                          input logic [1:0] m2, input logic m4, input bit ck_m2,
                          input logic wr, input logic wm, input logic [2:0] est, input int lat);
    ret_t e;
    opcode = op;
    e.nm = nm; e.m1 = m1; e.m2 = m2; e.m4 = m4; e.ck_m2 = ck_m2;
    e.wr = wr; e.wm = wm; e.est = est; e.lat = lat; e.ir = exp_ret;
    retire_q.push_back(e);
    exp_ret = exp_ret + 32'd1;
    wait_wepc(nm);
  endtask

  initial begin
    // reset state
    tick();
    push_snap("reset", 8'b0000_0000, 32'd0, 1'b1, 4'b0000);
    tick();
    reset = 1'b0;
    push_snap("idle", 8'b0000_0000, 32'd0, 1'b1, 4'b0000);
    tick();

    // first R instruction from IDLE
    run = 1'b1;
    do_instr_first();

    // back-to-back program with run held high
    run = 1'b1;
    do_instr("I",     I,  1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 4);
    do_instr("LOAD",  LD, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 5);
    do_instr("STORE", ST, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 4);
    flag = 1'b1;
    do_instr("BR_f1", BR, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 3);
    flag = 1'b0;
    do_instr("BR_f0", BR, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 3);
    do_instr("AUIPC", AU, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 4);
    do_instr("JAL",   JL, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 4);

    // illegal opcode: sticky ERRO with run still high
    opcode = BAD;
    wait_estado("erro_entry", 3'd6);
    for (int i = 0; i < 20; i++) begin
      push_snap("erro_hold", 8'b0000_1110, 32'd8, 1'b0, 4'b0000);
      tick();
    end
    reset = 1'b1;
    run = 1'b0;
    push_snap("erro_reset", 8'b0000_0000, 32'd0, 1'b1, 4'b0000);
    tick();
    reset = 1'b0;
    exp_ret = '0;
    push_snap("erro_cleared", 8'b0000_0000, 32'd0, 1'b1, 4'b0000);
    tick();

    // reset during MEM of a LOAD aborts it
    run = 1'b1;
    opcode = LD;
    wait_estado("load_mem", 3'd4);
    push_snap("load_mem", 8'b0000_0100, 32'd0, 1'b1, 4'b0000);
    @(negedge clock);
    #1;
    reset = 1'b1;
    run = 1'b0;
    push_snap("rst_mid_load", 8'b0000_0000, 32'd0, 1'b1, 4'b0000);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      push_snap("post_abort", 8'b0000_0000, 32'd0, 1'b1, 4'b0000);
    end
    tick();

    // instret wrap
    force dut.r_instret = 32'hFFFF_FFFF;
    tick();
    release dut.r_instret;
    exp_ret = 32'hFFFF_FFFF;
    run = 1'b1;
    do_instr("R_wrap", R, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 4);
    run = 1'b0;
    tick();
    push_snap("wrapped", 8'b0000_0000, 32'd0, 1'b0, 4'b0000);
    tick();
    tick();
    done = 1'b1;
  end

  // R from IDLE, also checking the FETCH cycle and the count after retirement.
  task automatic do_instr_first;
    ret_t e;
    opcode = R;
    e.nm = "R_first"; e.m1 = 1'b1; e.m2 = 2'd1; e.m4 = 1'b0; e.ck_m2 = 1'b1;
    e.wr = 1'b1; e.wm = 1'b0; e.est = 3'd5; e.lat = 4; e.ir = 32'd0;
    retire_q.push_back(e);
    exp_ret = 32'd1;
    tick();
    push_snap("R_fetch", 8'b1000_0001, 32'd0, 1'b0, 4'b0000);
    wait_wepc("R_first");
    run = 1'b0;
    tick();
    push_snap("R_retired", 8'b0000_0000, 32'd1, 1'b0, 4'b0000);
    tick();
  endtask

endmodule
